// File: rtl/regwb_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
// The long-latency result FIFO carries wb_entry_t {dest, data} records.
package regwb_pkg;
  localparam int REG_W         = 5;
  localparam int DATA_W        = 32;
  localparam int LU_FIFO_DEPTH = 2;
  localparam int NUM_REGS      = 1 << REG_W;
  localparam int CNT_W         = $clog2(LU_FIFO_DEPTH + 1);

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO for long-latency results, with 1-bit wrapping pointers.
// Payload storage is deliberately left out of reset; only pointers and count clear.
module wb_fifo2
  import regwb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count
);
  wb_entry_t        mem_r [LU_FIFO_DEPTH];
  logic             wr_ptr_r;
  logic             rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && (count_r < CNT_W'(LU_FIFO_DEPTH));
  assign do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= ~wr_ptr_r;
      if (do_pop_s)  rd_ptr_r <= ~rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_entry;
    end
  end
endmodule

// File: rtl/regwb_arbiter.sv
// Shares the register-file write port between the pipeline writeback and the
// long-latency result FIFO, and tracks in-flight long-latency destinations.
module regwb_arbiter
  import regwb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              MEMWB_RegWrite_out,
  input  logic [REG_W-1:0]  MEMWB_destination_out,
  input  logic [DATA_W-1:0] WBID_mux_out,
  input  logic              lu_valid,
  input  logic [REG_W-1:0]  lu_dest,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  input  logic              id_lu_issue,
  input  logic [REG_W-1:0]  id_lu_dest,
  input  logic [REG_W-1:0]  IDEX_rs_in,
  input  logic [REG_W-1:0]  IDEX_rt_in,
  input  logic [REG_W-1:0]  id_dest,
  output logic              id_stall,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);
  wb_entry_t            lu_entry_s;
  wb_entry_t            head_s;
  logic [CNT_W-1:0]     count_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 pipe_sel_s;
  logic [NUM_REGS-1:0]  pending_r;
  logic [NUM_REGS-1:0]  pending_nxt_s;

  // Pop decisions use the registered count, so a fresh push never pops in its own cycle
  assign lu_ready   = (count_s < CNT_W'(LU_FIFO_DEPTH));
  assign push_s     = lu_valid & lu_ready;
  assign pipe_sel_s = MEMWB_RegWrite_out & (MEMWB_destination_out != {REG_W{1'b0}});
  assign pop_s      = ~pipe_sel_s & (count_s != {CNT_W{1'b0}});
  assign lu_entry_s = '{dest: lu_dest, data: lu_data};

  wb_fifo2 u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (lu_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .count      (count_s)
  );

  // Scoreboard next state: clear on pop first so a same-cycle issue wins
  always_comb begin
    pending_nxt_s = pending_r;
    if (pop_s) begin
      pending_nxt_s[head_s.dest] = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
    if (id_lu_issue) begin
      pending_nxt_s[id_lu_dest] = 1'b1;
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Scoreboard state
  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_r <= {NUM_REGS{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
    end
  end

  assign id_stall = pending_r[IDEX_rs_in] | pending_r[IDEX_rt_in] | pending_r[id_dest];

  // Registered write port; address/data hold when idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= {REG_W{1'b0}};
      rf_wdata <= {DATA_W{1'b0}};
    end else if (pipe_sel_s) begin
      rf_we    <= 1'b1;
      rf_waddr <= MEMWB_destination_out;
      rf_wdata <= WBID_mux_out;
    end else if (pop_s) begin
      rf_we    <= (head_s.dest != {REG_W{1'b0}});
      rf_waddr <= head_s.dest;
      rf_wdata <= head_s.data;
    end else begin
      rf_we    <= 1'b0;
    end
  end
endmodule
